// File: rtl/cdc_pkg.sv
// Shared types and constants for the req/ack CDC link.
// Used by the receiver and the sender-side ack synchronizer.
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FULL = 2'd1,
        ACK  = 2'd2
    } rx_state_t;

    localparam int CDC_DEFAULT_WIDTH = 4;
    localparam int CDC_MIN_SYNC      = 2;

endpackage

// File: rtl/cdc_handshake_receiver_if.sv
// Sender-side req/data/ack link plus downstream valid/ready port.
// master = environment side, slave = receiver side.
interface cdc_handshake_receiver_if #(
    parameter int WIDTH = 4
);
    logic             req;
    logic [WIDTH-1:0] data;
    logic             ack;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             seq_err;
    logic [7:0]       rx_count;

    modport master (
        output req,
        output data,
        output out_ready,
        input  ack,
        input  out_data,
        input  out_valid,
        input  seq_err,
        input  rx_count
    );

    modport slave (
        input  req,
        input  data,
        input  out_ready,
        output ack,
        output out_data,
        output out_valid,
        output seq_err,
        output rx_count
    );
endinterface

// File: rtl/sync_ff.sv
// Multi-flop single-bit synchronizer, async reset to 0.
// Shared by the receiver req path and the sender ack path.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the asynchronous input one stage per clock.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchronizer flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/cdc_handshake_receiver.sv
// Destination end of the four-phase req/ack CDC link.
// Captures the word, hands it downstream, then acks.
module cdc_handshake_receiver
    import cdc_pkg::*;
#(
    parameter int WIDTH       = CDC_DEFAULT_WIDTH,
    parameter int SYNC_STAGES = CDC_MIN_SYNC,
    parameter bit CHECK_SEQ   = 1'b1
) (
    input logic                    clk,
    input logic                    rst,
    cdc_handshake_receiver_if.slave bus
);
    localparam int STAGES =
        (SYNC_STAGES < CDC_MIN_SYNC) ? CDC_MIN_SYNC : SYNC_STAGES;

    rx_state_t        state_q;
    rx_state_t        state_d;
    logic             req_s;
    logic             capture;
    logic             accept;

    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] out_data_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic             ack_q;
    logic             ack_d;
    logic [7:0]       rx_count_q;
    logic [7:0]       rx_count_d;

    sync_ff #(
        .STAGES (STAGES)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.req),
        .q   (req_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req_s) state_d = FULL;
            FULL: if (bus.out_ready) state_d = ACK;
            ACK:  if (!req_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: capture, accept and next register values.
    always_comb begin
        capture     = 1'b0;
        accept      = 1'b0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ack_d       = ack_q;
        rx_count_d  = rx_count_q;
        unique case (state_q)
            IDLE: begin
                if (req_s) begin
                    capture     = 1'b1;
                    out_data_d  = bus.data;
                    out_valid_d = 1'b1;
                end
            end
            FULL: begin
                if (bus.out_ready) begin
                    accept      = 1'b1;
                    out_valid_d = 1'b0;
                    ack_d       = 1'b1;
                    rx_count_d  = rx_count_q + 8'd1;
                end
            end
            ACK: begin
                if (!req_s) begin
                    ack_d = 1'b0;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                ack_d       = 1'b0;
            end
        endcase
    end

    // Capture register, handshake flops and transfer counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ack_q       <= 1'b0;
            rx_count_q  <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ack_q       <= ack_d;
            rx_count_q  <= rx_count_d;
        end
    end

    generate
        if (CHECK_SEQ) begin : g_seq
            logic [WIDTH-1:0] expected_q;
            logic [WIDTH-1:0] expected_d;
            logic             seq_err_q;
            logic             seq_err_d;

            // Compare each captured word against the running sequence.
            always_comb begin
                expected_d = expected_q;
                seq_err_d  = seq_err_q;
                if (capture) begin
                    expected_d = bus.data + WIDTH'(1);
                    if (bus.data != expected_q) begin
                        seq_err_d = 1'b1;
                    end
                end
            end

            // Sequence tracker; the error flag is sticky until reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    expected_q <= WIDTH'(1);
                    seq_err_q  <= 1'b0;
                end else begin
                    expected_q <= expected_d;
                    seq_err_q  <= seq_err_d;
                end
            end

            assign bus.seq_err = seq_err_q;
        end else begin : g_noseq
            assign bus.seq_err = 1'b0;
        end
    endgenerate

    logic unused_accept;
    assign unused_accept = accept;

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ack       = ack_q;
    assign bus.rx_count  = rx_count_q;
endmodule

// File: tb/tb_cdc_handshake_receiver.sv
// Scoreboard bench for the CDC handshake receiver.
// Words are queued when req rises and checked on acceptance.
module tb_cdc_handshake_receiver;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [3:0] sb[$];
    logic [7:0] model_cnt;

    cdc_handshake_receiver_if #(.WIDTH(4)) bus ();

    cdc_handshake_receiver #(
        .WIDTH       (4),
        .SYNC_STAGES (2),
        .CHECK_SEQ   (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: compare each accepted word against the queue.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_pop: accepted %h, required queued word",
                         bus.out_data);
            end else begin
                logic [3:0] exp_w;
                exp_w = sb.pop_front();
                if (bus.out_data !== exp_w) begin
                    errors++;
                    $display("FAIL sb_data: got %h exp %h",
                             bus.out_data, exp_w);
                end
            end
            model_cnt = model_cnt + 8'd1;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.req = 1'b0;
        bus.data = 4'h0;
        bus.out_ready = 1'b0;
        sb.delete();
        model_cnt = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // which: 0 = ack, 1 = out_valid
    task automatic wait_sig(input int which, input logic val,
                            input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (which == 0) hit = (bus.ack === val);
            else            hit = (bus.out_valid === val);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: timeout waiting for %b", name, val);
        end
    endtask

    task automatic raise(input logic [3:0] w);
        @(posedge clk);
        #1;
        bus.data = w;
        bus.req = 1'b1;
        sb.push_back(w);
    endtask

    task automatic finish_xfer();
        wait_sig(0, 1'b1, "ack_rise");
        @(posedge clk);
        #1 bus.req = 1'b0;
        wait_sig(0, 1'b0, "ack_fall");
    endtask

    task automatic send(input logic [3:0] w);
        raise(w);
        finish_xfer();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.out_data !== 4'h0 || bus.seq_err !== 1'b0 ||
            bus.rx_count !== 8'd0) begin
            errors++;
            $display("FAIL reset: ack=%b vld=%b d=%h err=%b cnt=%0d exp 0",
                     bus.ack, bus.out_valid, bus.out_data,
                     bus.seq_err, bus.rx_count);
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.out_ready = 1'b1;
        raise(4'h1);
        wait_sig(1, 1'b1, "single_valid");
        checks++;
        if (bus.out_data !== 4'h1 || bus.ack !== 1'b0) begin
            errors++;
            $display("FAIL single_cap: d=%h ack=%b exp 1/0",
                     bus.out_data, bus.ack);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.ack !== 1'b1) begin
            errors++;
            $display("FAIL single_pulse: vld=%b ack=%b exp 0/1",
                     bus.out_valid, bus.ack);
        end
        finish_xfer();
        checks++;
        if (bus.rx_count !== 8'd1 || bus.seq_err !== 1'b0) begin
            errors++;
            $display("FAIL single_end: cnt=%0d err=%b exp 1/0",
                     bus.rx_count, bus.seq_err);
        end
        checks++;
        if (bus.out_data !== 4'h1) begin
            errors++;
            $display("FAIL single_hold: d=%h exp 1", bus.out_data);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        do_reset();
        raise(4'h1);
        wait_sig(1, 1'b1, "bp_valid");
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.ack !== 1'b0) begin
                errors++;
                bad++;
                $display("FAIL bp_hold%0d: vld=%b ack=%b exp 1/0",
                         i, bus.out_valid, bus.ack);
            end
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.ack !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: vld=%b ack=%b exp 0/1",
                     bus.out_valid, bus.ack);
        end
        finish_xfer();
        checks++;
        if (bus.rx_count !== model_cnt) begin
            errors++;
            $display("FAIL bp_cnt: cnt=%0d exp %0d",
                     bus.rx_count, model_cnt);
        end
    endtask

    task automatic test_seq_wrap();
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 15; i++) send(4'(i));
        send(4'h0);
        checks++;
        if (bus.out_data !== 4'h0) begin
            errors++;
            $display("FAIL wrap_data: d=%h exp 0", bus.out_data);
        end
        send(4'h1);
        checks++;
        if (bus.seq_err !== 1'b0 || bus.rx_count !== 8'd17) begin
            errors++;
            $display("FAIL wrap_end: err=%b cnt=%0d exp 0/17",
                     bus.seq_err, bus.rx_count);
        end
    endtask

    task automatic test_seq_error();
        do_reset();
        bus.out_ready = 1'b1;
        send(4'h1);
        send(4'h2);
        checks++;
        if (bus.seq_err !== 1'b0) begin
            errors++;
            $display("FAIL seqerr_pre: err=%b exp 0", bus.seq_err);
        end
        raise(4'h4);
        wait_sig(1, 1'b1, "seqerr_valid");
        checks++;
        if (bus.seq_err !== 1'b1) begin
            errors++;
            $display("FAIL seqerr_set: err=%b exp 1", bus.seq_err);
        end
        finish_xfer();
        send(4'h5);
        checks++;
        if (bus.seq_err !== 1'b1 || bus.rx_count !== 8'd4) begin
            errors++;
            $display("FAIL seqerr_sticky: err=%b cnt=%0d exp 1/4",
                     bus.seq_err, bus.rx_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.out_ready = 1'b1;
        send(4'h1);
        send(4'h2);
        raise(4'h3);
        wait_sig(0, 1'b1, "mid_ack");
        @(negedge clk);
        #1;
        rst = 1'b1;
        bus.out_ready = 1'b0;
        sb.delete();
        model_cnt = 8'd0;
        #1;
        checks++;
        if (bus.ack !== 1'b0) begin
            errors++;
            $display("FAIL mid_ack_drop: ack=%b exp 0", bus.ack);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.push_back(4'h3);
        wait_sig(1, 1'b1, "mid_recap");
        checks++;
        if (bus.out_data !== 4'h3 || bus.seq_err !== 1'b1 ||
            bus.rx_count !== 8'd0) begin
            errors++;
            $display("FAIL mid_recap: d=%h err=%b cnt=%0d exp 3/1/0",
                     bus.out_data, bus.seq_err, bus.rx_count);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        finish_xfer();
        checks++;
        if (bus.rx_count !== 8'd1) begin
            errors++;
            $display("FAIL mid_cnt: cnt=%0d exp 1", bus.rx_count);
        end
    endtask

    task automatic test_count_wrap();
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) send(4'((i + 1) & 15));
        checks++;
        if (bus.rx_count !== 8'd0 || bus.rx_count !== model_cnt) begin
            errors++;
            $display("FAIL cnt_wrap256: cnt=%0d exp 0", bus.rx_count);
        end
        send(4'h1);
        checks++;
        if (bus.rx_count !== 8'd1 || bus.seq_err !== 1'b0) begin
            errors++;
            $display("FAIL cnt_wrap257: cnt=%0d err=%b exp 1/0",
                     bus.rx_count, bus.seq_err);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_cnt = 8'd0;
        rst = 1'b1;
        bus.req = 1'b0;
        bus.data = 4'h0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_seq_wrap();
        test_seq_error();
        test_reset_mid();
        test_count_wrap();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_left: %0d words unaccepted, exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
